// File: rtl/pc_redirect_ctrl_if.sv
// Signal bundle between the fetch redirect controller and its neighbours
// (EX, trap logic, hazard unit, instruction memory, debug, PC register).
interface pc_redirect_ctrl_if;
   logic        br_valid;
   logic [31:0] br_target;
   logic        trap_valid;
   logic [31:0] trap_vec;
   logic        hz_stall;
   logic        imem_ready;
   logic        halt_req;
   logic        resume_req;
   logic        pc_br_ctrl;
   logic [31:0] pc_br_addr;
   logic        pc_stall;
   logic        flush;
   logic [1:0]  state_o;
   logic [15:0] redirect_cnt;

   modport master (
      output br_valid, br_target, trap_valid, trap_vec, hz_stall,
             imem_ready, halt_req, resume_req,
      input  pc_br_ctrl, pc_br_addr, pc_stall, flush, state_o, redirect_cnt
   );

   modport slave (
      input  br_valid, br_target, trap_valid, trap_vec, hz_stall,
             imem_ready, halt_req, resume_req,
      output pc_br_ctrl, pc_br_addr, pc_stall, flush, state_o, redirect_cnt
   );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Fetch PC sequencer: boot redirect, branch/trap arbitration, pending redirects
// while instruction memory is busy, and debug halt/resume.
module pc_redirect_ctrl #(
   parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
   parameter int unsigned BOOT_DELAY = 2
) (
   input logic               clk,
   input logic               rst,
   pc_redirect_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2,
      ST_HALT = 2'd3
   } state_t;

   localparam logic [3:0] BOOT_LAST = 4'(BOOT_DELAY - 1);

   state_t      state_q, state_d;
   logic [3:0]  boot_cnt_q, boot_cnt_d;
   logic        pend_vld_q, pend_vld_d;
   logic        pend_trap_q, pend_trap_d;
   logic [31:0] pend_addr_q, pend_addr_d;
   logic [15:0] redir_cnt_q;

   logic        br_ctrl, stall, flush, accept;
   logic [31:0] br_addr, win_addr, pend_issue_addr;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_comb begin
      state_d     = state_q;
      boot_cnt_d  = boot_cnt_q;
      pend_vld_d  = pend_vld_q;
      pend_trap_d = pend_trap_q;
      pend_addr_d = pend_addr_q;
      br_ctrl     = 1'b0;
      br_addr     = 32'h0;
      stall       = 1'b1;
      flush       = 1'b0;
      accept      = 1'b0;
      win_addr    = bus.trap_valid ? bus.trap_vec : bus.br_target;
      // A trap arriving while a branch waits overrides it, even in the issue cycle.
      pend_issue_addr = (bus.trap_valid && !pend_trap_q) ? bus.trap_vec : pend_addr_q;

      case (state_q)
         ST_BOOT: begin
            boot_cnt_d = boot_cnt_q + 4'd1;
            if (boot_cnt_q == BOOT_LAST) begin
               br_ctrl    = 1'b1;
               br_addr    = RESET_VEC;
               stall      = 1'b0;
               flush      = 1'b1;
               boot_cnt_d = 4'd0;
               state_d    = ST_RUN;
            end
         end
         ST_RUN: begin
            if (bus.trap_valid || bus.br_valid) begin
               accept = 1'b1;
            end else if (bus.halt_req) begin
               state_d = ST_HALT;
            end else begin
               stall = bus.hz_stall | ~bus.imem_ready;
            end
         end
         ST_PEND: begin
            if (bus.trap_valid && !pend_trap_q) begin
               pend_addr_d = bus.trap_vec;
               pend_trap_d = 1'b1;
            end
            if (bus.imem_ready && pend_vld_q) begin
               br_ctrl     = 1'b1;
               br_addr     = pend_issue_addr;
               stall       = 1'b0;
               pend_vld_d  = 1'b0;
               pend_trap_d = 1'b0;
               state_d     = ST_RUN;
            end
         end
         default: begin
            if (bus.trap_valid) begin
               accept = 1'b1;
            end else if (bus.resume_req && !bus.halt_req) begin
               state_d = ST_RUN;
            end
         end
      endcase

      // Accepted redirect: issue now if memory is ready, otherwise park it in PEND.
      if (accept) begin
         flush = 1'b1;
         if (bus.imem_ready) begin
            br_ctrl = 1'b1;
            br_addr = win_addr;
            stall   = 1'b0;
            state_d = ST_RUN;
         end else begin
            pend_vld_d  = 1'b1;
            pend_trap_d = bus.trap_valid;
            pend_addr_d = win_addr;
            state_d     = ST_PEND;
         end
      end

      if (!rst) begin
         br_ctrl = 1'b0;
         br_addr = 32'h0;
         stall   = 1'b1;
         flush   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= ST_BOOT;
         boot_cnt_q  <= 4'd0;
         pend_vld_q  <= 1'b0;
         pend_trap_q <= 1'b0;
         redir_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         boot_cnt_q  <= boot_cnt_d;
         pend_vld_q  <= pend_vld_d;
         pend_trap_q <= pend_trap_d;
         if (br_ctrl) begin
            redir_cnt_q <= sat_inc16(redir_cnt_q);
         end
      end
   end

   // Pending address is pure data; its valid bit alone guards it.
   always_ff @(posedge clk) begin
      pend_addr_q <= pend_addr_d;
   end

   assign bus.pc_br_ctrl   = br_ctrl;
   assign bus.pc_br_addr   = br_addr;
   assign bus.pc_stall     = stall;
   assign bus.flush        = flush;
   assign bus.state_o      = state_q;
   assign bus.redirect_cnt = redir_cnt_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl: boot, immediate and pended redirects,
// arbitration, halt/resume and reset while a redirect is pending.
module tb_pc_redirect_ctrl;

   logic clk = 1'b0;
   logic rst;
   int   errs   = 0;
   int   checks = 0;

   pc_redirect_ctrl_if bus ();

   pc_redirect_ctrl #(
      .RESET_VEC  (32'h0000_0100),
      .BOOT_DELAY (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      rst            = 1'b0;
      bus.br_valid   = 1'b0;
      bus.br_target  = 32'h0;
      bus.trap_valid = 1'b0;
      bus.trap_vec   = 32'h0;
      bus.hz_stall   = 1'b0;
      bus.imem_ready = 1'b1;
      bus.halt_req   = 1'b0;
      bus.resume_req = 1'b0;
      tick();
      tick();
      settle();
      chk("rst_stall", bus.pc_stall, 1);
      chk("rst_ctrl", bus.pc_br_ctrl, 0);
      chk("rst_addr", bus.pc_br_addr, 0);
      chk("rst_flush", bus.flush, 0);
      chk("rst_state", bus.state_o, 0);
      chk("rst_cnt", bus.redirect_cnt, 0);

      // Boot: cycle 0 stalled, cycle 1 redirects to RESET_VEC
      rst = 1'b1;
      settle();
      chk("boot0_stall", bus.pc_stall, 1);
      chk("boot0_ctrl", bus.pc_br_ctrl, 0);
      tick();
      settle();
      chk("boot1_ctrl", bus.pc_br_ctrl, 1);
      chk("boot1_addr", bus.pc_br_addr, 32'h100);
      chk("boot1_flush", bus.flush, 1);
      chk("boot1_stall", bus.pc_stall, 0);
      chk("boot1_state", bus.state_o, 0);
      tick();
      settle();
      chk("run_state", bus.state_o, 1);
      chk("run_cnt", bus.redirect_cnt, 1);
      chk("run_idle_stall", bus.pc_stall, 0);

      bus.hz_stall = 1'b1;
      settle();
      chk("hz_stall", bus.pc_stall, 1);
      chk("hz_ctrl", bus.pc_br_ctrl, 0);
      bus.hz_stall = 1'b0;

      // Immediate branch
      bus.br_valid  = 1'b1;
      bus.br_target = 32'h40;
      settle();
      chk("br_ctrl", bus.pc_br_ctrl, 1);
      chk("br_addr", bus.pc_br_addr, 32'h40);
      chk("br_flush", bus.flush, 1);
      chk("br_stall", bus.pc_stall, 0);
      tick();
      bus.br_valid = 1'b0;
      settle();
      chk("br_cnt", bus.redirect_cnt, 2);
      chk("br_state", bus.state_o, 1);

      // Trap beats branch, and beats hazard stall
      bus.br_valid   = 1'b1;
      bus.trap_valid = 1'b1;
      bus.trap_vec   = 32'h800;
      bus.hz_stall   = 1'b1;
      settle();
      chk("prio_addr", bus.pc_br_addr, 32'h800);
      chk("prio_ctrl", bus.pc_br_ctrl, 1);
      chk("prio_stall", bus.pc_stall, 0);
      tick();
      bus.br_valid   = 1'b0;
      bus.trap_valid = 1'b0;
      bus.hz_stall   = 1'b0;
      settle();
      chk("prio_cnt", bus.redirect_cnt, 3);

      // Branch pended by busy memory, then replaced by a trap
      bus.br_valid   = 1'b1;
      bus.imem_ready = 1'b0;
      settle();
      chk("cap_flush", bus.flush, 1);
      chk("cap_ctrl", bus.pc_br_ctrl, 0);
      chk("cap_stall", bus.pc_stall, 1);
      tick();
      bus.br_valid   = 1'b0;
      bus.trap_valid = 1'b1;
      settle();
      chk("pend_state", bus.state_o, 2);
      chk("pend_flush", bus.flush, 0);
      chk("pend_ctrl", bus.pc_br_ctrl, 0);
      tick();
      bus.trap_valid = 1'b0;
      bus.br_valid   = 1'b1;
      bus.br_target  = 32'h44;
      settle();
      chk("pend_wait1_ctrl", bus.pc_br_ctrl, 0);
      chk("pend_wait1_flush", bus.flush, 0);
      tick();
      bus.br_valid = 1'b0;
      settle();
      chk("pend_wait2_ctrl", bus.pc_br_ctrl, 0);
      chk("pend_wait2_stall", bus.pc_stall, 1);
      tick();
      bus.imem_ready = 1'b1;
      settle();
      chk("pend_issue_ctrl", bus.pc_br_ctrl, 1);
      chk("pend_issue_addr", bus.pc_br_addr, 32'h800);
      chk("pend_issue_stall", bus.pc_stall, 0);
      chk("pend_issue_flush", bus.flush, 0);
      tick();
      settle();
      chk("pend_done_state", bus.state_o, 1);
      chk("pend_done_ctrl", bus.pc_br_ctrl, 0);
      chk("pend_done_cnt", bus.redirect_cnt, 4);

      // Halt / resume
      bus.halt_req = 1'b1;
      settle();
      chk("halt_stall", bus.pc_stall, 1);
      chk("halt_ctrl", bus.pc_br_ctrl, 0);
      tick();
      bus.resume_req = 1'b1;
      settle();
      chk("halt_state", bus.state_o, 3);
      tick();
      bus.resume_req = 1'b0;
      bus.halt_req   = 1'b0;
      settle();
      chk("halt_ignore_resume", bus.state_o, 3);
      chk("halt_hold_stall", bus.pc_stall, 1);
      tick();
      settle();
      chk("halt_no_resume", bus.state_o, 3);
      bus.resume_req = 1'b1;
      tick();
      bus.resume_req = 1'b0;
      settle();
      chk("resume_state", bus.state_o, 1);

      // Trap leaves HALT with an immediate redirect
      bus.halt_req = 1'b1;
      tick();
      bus.trap_vec   = 32'h900;
      bus.trap_valid = 1'b1;
      settle();
      chk("htrap_ctrl", bus.pc_br_ctrl, 1);
      chk("htrap_addr", bus.pc_br_addr, 32'h900);
      chk("htrap_stall", bus.pc_stall, 0);
      tick();
      bus.trap_valid = 1'b0;
      bus.halt_req   = 1'b0;
      settle();
      chk("htrap_state", bus.state_o, 1);
      chk("htrap_cnt", bus.redirect_cnt, 5);

      // Reset while pending discards the redirect
      bus.br_valid   = 1'b1;
      bus.br_target  = 32'h40;
      bus.imem_ready = 1'b0;
      tick();
      bus.br_valid = 1'b0;
      settle();
      chk("rp_state", bus.state_o, 2);
      rst            = 1'b0;
      bus.imem_ready = 1'b1;
      settle();
      chk("rp_rst_ctrl", bus.pc_br_ctrl, 0);
      chk("rp_rst_stall", bus.pc_stall, 1);
      tick();
      settle();
      chk("rp_boot_state", bus.state_o, 0);
      chk("rp_cnt", bus.redirect_cnt, 0);
      rst = 1'b1;
      settle();
      chk("rp_boot0_ctrl", bus.pc_br_ctrl, 0);
      tick();
      settle();
      chk("rp_boot1_ctrl", bus.pc_br_ctrl, 1);
      chk("rp_boot1_addr", bus.pc_br_addr, 32'h100);
      tick();
      settle();
      chk("rp_run_state", bus.state_o, 1);
      chk("rp_run_ctrl", bus.pc_br_ctrl, 0);
      chk("rp_run_cnt", bus.redirect_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
